trig_lookup_arbiter: RTL and testbench

- Shares one combinational sine lookup table (integer degrees in, signed Q8 sine out, 256 = 1.0) between two requesters, e.g. the forward and inverse coordinate-transform units of the image-rotation path.
- For each granted request, reads sin(angle) and then cos(angle) = sin(angle+90) from the same table port on consecutive cycles.
- Returns both values with a one-cycle ack.
- Sits between the rotation-angle consumers and the single table instance.

---
 rtl/trig_lookup_arbiter.sv | 146 ++++++++++++++
 tb/tb_trig_lookup_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_lookup_arbiter.sv
// Two-requester arbiter in front of one combinational sine table.
// Each granted request reads sin(n) and then sin(n+90) = cos(n) from the
// shared table port on consecutive cycles and returns both with a one-cycle
// ack. The angle is normalised to 0..359 when it is granted.
module trig_lookup_arbiter #(
    parameter int ANGLE_W = 10,
    parameter int DATA_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic [ANGLE_W-1:0]        angle0,
    input  logic                      req1,
    input  logic [ANGLE_W-1:0]        angle1,
    output logic                      ack0,
    output logic                      ack1,
    output logic signed [DATA_W-1:0]  sin_out,
    output logic signed [DATA_W-1:0]  cos_out,
    output logic                      busy,
    output logic [ANGLE_W-1:0]        tbl_angle,
    input  logic signed [DATA_W-1:0]  tbl_sin
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOK_SIN = 2'd1,
        LOOK_COS = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Wide constants so the normalisation and +90 wrap never overflow.
    localparam logic [ANGLE_W:0] DEG_90  = (ANGLE_W+1)'(90);
    localparam logic [ANGLE_W:0] DEG_360 = (ANGLE_W+1)'(360);
    localparam logic [ANGLE_W:0] DEG_720 = (ANGLE_W+1)'(720);

    state_t                     state_reg, state_next;
    logic                       last_grant_reg, last_grant_next;
    logic [ANGLE_W-1:0]         angle_reg, angle_next;
    logic [ANGLE_W-1:0]         tbl_angle_reg, tbl_angle_next;
    logic signed [DATA_W-1:0]   sin_reg, sin_next;
    logic signed [DATA_W-1:0]   sin_out_reg, sin_out_next;
    logic signed [DATA_W-1:0]   cos_out_reg, cos_out_next;
    logic [1:0]                 ack_reg, ack_next;

    logic                       pick_grant;
    logic [ANGLE_W-1:0]         pick_angle;
    logic [ANGLE_W:0]           pick_wide;
    logic [ANGLE_W-1:0]         norm_angle;
    logic [ANGLE_W:0]           cos_wide;
    logic [ANGLE_W-1:0]         cos_angle;

    // Round-robin pick, angle normalisation and cosine address wrap.
    always_comb begin
        if (req0 && req1) begin
            pick_grant = ~last_grant_reg;
        end else begin
            pick_grant = req1;
        end
        pick_angle = pick_grant ? angle1 : angle0;
        pick_wide  = {1'b0, pick_angle};
        if (pick_wide >= DEG_720) begin
            norm_angle = ANGLE_W'(pick_wide - DEG_720);
        end else if (pick_wide >= DEG_360) begin
            norm_angle = ANGLE_W'(pick_wide - DEG_360);
        end else begin
            norm_angle = pick_angle;
        end
        cos_wide = {1'b0, angle_reg} + DEG_90;
        if (cos_wide >= DEG_360) begin
            cos_angle = ANGLE_W'(cos_wide - DEG_360);
        end else begin
            cos_angle = ANGLE_W'(cos_wide);
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        angle_next      = angle_reg;
        tbl_angle_next  = tbl_angle_reg;
        sin_next        = sin_reg;
        sin_out_next    = sin_out_reg;
        cos_out_next    = cos_out_reg;
        ack_next        = 2'b00;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_next = pick_grant;
                    angle_next      = norm_angle;
                    tbl_angle_next  = norm_angle;
                    state_next      = LOOK_SIN;
                end
            end
            LOOK_SIN: begin
                sin_next       = tbl_sin;
                tbl_angle_next = cos_angle;
                state_next     = LOOK_COS;
            end
            LOOK_COS: begin
                // Results and ack are loaded together so they appear in RESP.
                sin_out_next = sin_reg;
                cos_out_next = tbl_sin;
                ack_next     = last_grant_reg ? 2'b10 : 2'b01;
                state_next   = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            angle_reg      <= '0;
            tbl_angle_reg  <= '0;
            sin_reg        <= '0;
            sin_out_reg    <= '0;
            cos_out_reg    <= '0;
            ack_reg        <= 2'b00;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            angle_reg      <= angle_next;
            tbl_angle_reg  <= tbl_angle_next;
            sin_reg        <= sin_next;
            sin_out_reg    <= sin_out_next;
            cos_out_reg    <= cos_out_next;
            ack_reg        <= ack_next;
        end
    end

    assign ack0      = ack_reg[0];
    assign ack1      = ack_reg[1];
    assign sin_out   = sin_out_reg;
    assign cos_out   = cos_out_reg;
    assign tbl_angle = tbl_angle_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Bench for trig_lookup_arbiter: directed scenarios followed by randomized
// requesters, checked every cycle against a transaction-level model.
module tb_trig_lookup_arbiter;

    logic              clk;
    logic              rst_n;
    logic              req0, req1;
    logic [9:0]        angle0, angle1;
    logic              ack0, ack1, busy;
    logic signed [9:0] sin_out, cos_out, tbl_sin;
    logic [9:0]        tbl_angle;

    int errors = 0;
    int checks = 0;

    // Sine table contents: 256*sin(deg), truncated toward zero.
    int sin_tbl [1024];

    // Model state: cycles since grant (0 = idle), grant and last winner.
    int m_count, m_grant, m_last, m_n, m_tbl;
    int m_sin_out, m_cos_out;

    trig_lookup_arbiter #(.ANGLE_W(10), .DATA_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .angle0   (angle0),
        .req1     (req1),
        .angle1   (angle1),
        .ack0     (ack0),
        .ack1     (ack1),
        .sin_out  (sin_out),
        .cos_out  (cos_out),
        .busy     (busy),
        .tbl_angle(tbl_angle),
        .tbl_sin  (tbl_sin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational table model.
    always_comb tbl_sin = 10'(sin_tbl[tbl_angle]);

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_grant   = 0;
        m_last    = 1;
        m_n       = 0;
        m_tbl     = 0;
        m_sin_out = 0;
        m_cos_out = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_edge();
        if (m_count == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_grant = 1 - m_last;
                else              m_grant = req1 ? 1 : 0;
                m_last  = m_grant;
                m_n     = (m_grant == 1 ? int'(angle1) : int'(angle0)) % 360;
                m_tbl   = m_n;
                m_count = 1;
            end
        end else if (m_count == 1) begin
            m_tbl   = (m_n + 90) % 360;
            m_count = 2;
        end else if (m_count == 2) begin
            m_sin_out = sin_tbl[m_n];
            m_cos_out = sin_tbl[(m_n + 90) % 360];
            m_count   = 3;
        end else begin
            m_count = 0;
        end
    endtask

    // One clock: advance, then compare every output with the model.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_val("busy", busy, (m_count != 0) ? 1 : 0);
        check_val("ack0", ack0, (m_count == 3 && m_grant == 0) ? 1 : 0);
        check_val("ack1", ack1, (m_count == 3 && m_grant == 1) ? 1 : 0);
        check_val("sin_out", sin_out, m_sin_out);
        check_val("cos_out", cos_out, m_cos_out);
        check_val("tbl_angle", tbl_angle, m_tbl);
        check_val("tbl_range", (tbl_angle < 10'd360) ? 1 : 0, 1);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_ack0", ack0, 0);
        check_val("rst_ack1", ack1, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_sin", sin_out, 0);
        check_val("rst_cos", cos_out, 0);
        check_val("rst_tbl", tbl_angle, 0);
        model_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Single isolated request with explicit expected addresses and results.
    task automatic single(input int who, input int ang, input int e_t1,
                          input int e_t2, input int e_s, input int e_c);
        if (who == 0) begin req0 = 1'b1; angle0 = 10'(ang); end
        else          begin req1 = 1'b1; angle1 = 10'(ang); end
        step();
        check_val("dir_busy", busy, 1);
        check_val("dir_sin_addr", tbl_angle, e_t1);
        step();
        check_val("dir_cos_addr", tbl_angle, e_t2);
        step();
        check_val("dir_ack", (who == 0) ? ack0 : ack1, 1);
        check_val("dir_sin", sin_out, e_s);
        check_val("dir_cos", cos_out, e_c);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        step();
        check_val("dir_idle", busy, 0);
    endtask

    // Randomized requester behaviour for one side.
    task automatic drive_req(input int r);
        logic       cur_req, cur_ack;
        logic [9:0] cur_ang;
        cur_req = (r == 1) ? req1 : req0;
        cur_ack = (r == 1) ? ack1 : ack0;
        cur_ang = (r == 1) ? angle1 : angle0;
        if (cur_ack && cur_req) begin
            if ($urandom_range(3) != 0) cur_req = 1'b0;
        end else if (!cur_req) begin
            if ($urandom_range(2) == 0) begin
                cur_req = 1'b1;
                cur_ang = 10'($urandom_range(1023));
            end
        end else if ($urandom_range(15) == 0) begin
            cur_ang = 10'($urandom_range(1023));
        end
        if (r == 1) begin req1 = cur_req; angle1 = cur_ang; end
        else        begin req0 = cur_req; angle0 = cur_ang; end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sin_tbl[i] = $rtoi(256.0 * $sin(real'(i) * 3.141592653589793 / 180.0));
        end
        rst_n  = 1'b1;
        req0   = 1'b0;
        req1   = 1'b0;
        angle0 = '0;
        angle1 = '0;
        model_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("reset_busy", busy, 0);
        check_val("reset_ack0", ack0, 0);
        check_val("reset_sin", sin_out, 0);
        check_val("reset_tbl", tbl_angle, 0);
        rst_n = 1'b1;

        // Plain requests, including wrap of the cosine address and >=360 inputs.
        single(0, 30, 30, 120, 127, 221);
        single(1, 300, 300, 30, -221, 127);
        single(0, 450, 90, 180, 256, 0);
        single(0, 1000, 280, 10, -252, 44);

        // Both held from reset: 0 wins first, then alternation.
        step();
        async_reset_check();
        req0 = 1'b1; angle0 = 10'd0;
        req1 = 1'b1; angle1 = 10'd90;
        repeat (3) step();
        check_val("rr_first_ack0", ack0, 1);
        check_val("rr_first_sin", sin_out, 0);
        check_val("rr_first_cos", cos_out, 256);
        repeat (4) step();
        check_val("rr_second_ack1", ack1, 1);
        check_val("rr_second_ack0", ack0, 0);
        check_val("rr_second_sin", sin_out, 256);
        check_val("rr_second_cos", cos_out, 0);
        repeat (4) step();
        check_val("rr_third_ack0", ack0, 1);
        check_val("rr_third_sin", sin_out, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        check_val("rr_ack0_one_cycle", ack0, 0);

        // Angle changed during LOOK_SIN does not affect the latched angle.
        req0 = 1'b1; angle0 = 10'd45;
        step();
        angle0 = 10'd135;
        step();
        step();
        check_val("latch_ack0", ack0, 1);
        check_val("latch_sin", sin_out, 181);
        check_val("latch_cos", cos_out, 181);
        req0 = 1'b0;
        step();

        // Request dropped early is still acknowledged.
        req1 = 1'b1; angle1 = 10'd60;
        step();
        req1 = 1'b0;
        step();
        step();
        check_val("early_drop_ack1", ack1, 1);
        step();

        // Reset during LOOK_COS aborts without ack, then a fresh request.
        req0 = 1'b1; angle0 = 10'd10;
        step();
        step();
        check_val("abort_in_cos", tbl_angle, 100);
        async_reset_check();
        step();
        check_val("abort_no_ack", ack0, 0);
        step();
        check_val("abort_still_no_ack", ack0, 0);
        single(0, 270, 270, 0, -256, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(299) == 0) begin
                async_reset_check();
            end else begin
                drive_req(0);
                drive_req(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
